// File: rtl/data_ram_if.sv
// Core-to-data-memory bus: read port, write port and busy indication.
interface data_ram_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUS_WIDTH  = 8
);
  logic                  ram_rd_en;
  logic [BUS_WIDTH-1:0]  addr_rd;
  logic                  ram_wr_en;
  logic [BUS_WIDTH-1:0]  addr_wr;
  logic [DATA_WIDTH-1:0] data_wr;
  logic [DATA_WIDTH-1:0] data_rd;
  logic                  ram_busy;

  modport master (
    output ram_rd_en, addr_rd, ram_wr_en, addr_wr, data_wr,
    input  data_rd, ram_busy
  );

  modport slave (
    input  ram_rd_en, addr_rd, ram_wr_en, addr_wr, data_wr,
    output data_rd, ram_busy
  );
endinterface

// File: rtl/data_ram.sv
// Single-clock 1R1W data memory with one memory-mapped I/O word (LEDs out, switches in).
// Optional macro RAM_CLEAR_EN: zero the whole array after every reset, busy while clearing.
module data_ram #(
  parameter int unsigned          DATA_WIDTH = 8,
  parameter int unsigned          BUS_WIDTH  = 8,
  parameter logic [BUS_WIDTH-1:0] IO_ADDR    = {BUS_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rstn,
  data_ram_if.slave             bus,
  input  logic [DATA_WIDTH-1:0] io_in,
  output logic [DATA_WIDTH-1:0] io_out
);

  localparam int unsigned DEPTH = 2 ** BUS_WIDTH;

`ifdef RAM_CLEAR_EN
  typedef enum logic {SCLEAR, SREADY} state_t;
  localparam state_t RST_STATE = SCLEAR;
  logic [BUS_WIDTH-1:0] clr_cnt;
  logic [BUS_WIDTH-1:0] clr_cnt_nxt;
`else
  typedef enum logic {SREADY} state_t;
  localparam state_t RST_STATE = SREADY;
`endif

  state_t                state;
  state_t                state_nxt;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  mem_we;
  logic [BUS_WIDTH-1:0]  mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] data_rd_q;
  logic [DATA_WIDTH-1:0] io_sync1;
  logic [DATA_WIDTH-1:0] io_sync2;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // State register (and clear counter when present)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= RST_STATE;
`ifdef RAM_CLEAR_EN
      clr_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
`ifdef RAM_CLEAR_EN
      clr_cnt <= clr_cnt_nxt;
`endif
    end
  end

  // Next state and array write-port steering
  always_comb begin
    state_nxt = state;
    rd_acc    = 1'b0;
    wr_acc    = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = bus.addr_wr;
    mem_wd    = bus.data_wr;
`ifdef RAM_CLEAR_EN
    clr_cnt_nxt = clr_cnt;
`endif
    case (state)
`ifdef RAM_CLEAR_EN
      SCLEAR: begin
        mem_we      = 1'b1;
        mem_wa      = clr_cnt;
        mem_wd      = '0;
        clr_cnt_nxt = clr_cnt + BUS_WIDTH'(1);
        if (clr_cnt == {BUS_WIDTH{1'b1}}) state_nxt = SREADY;
      end
`endif
      SREADY: begin
        rd_acc = bus.ram_rd_en;
        wr_acc = bus.ram_wr_en;
        mem_we = bus.ram_wr_en;
      end
      default: state_nxt = SREADY;
    endcase
  end

`ifdef RAM_CLEAR_EN
  assign bus.ram_busy = (state == SCLEAR);
`else
  assign bus.ram_busy = 1'b0;
`endif

  // Array write; reset leaves contents alone
  always_ff @(posedge clk) begin
    if (rstn && mem_we) mem[mem_wa] <= mem_wd;
  end

  // Read data, LED register and switch synchroniser
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_rd_q <= '0;
      io_out    <= '0;
      io_sync1  <= '0;
      io_sync2  <= '0;
    end else begin
      io_sync1 <= io_in;
      io_sync2 <= io_sync1;
      if (rd_acc) begin
        if (wr_acc && (bus.addr_wr == bus.addr_rd)) data_rd_q <= bus.data_wr;
        else if (bus.addr_rd == IO_ADDR)            data_rd_q <= io_sync2;
        else                                        data_rd_q <= mem[bus.addr_rd];
      end
      if (wr_acc && (bus.addr_wr == IO_ADDR)) io_out <= bus.data_wr;
    end
  end

  assign bus.data_rd = data_rd_q;

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: directed vector table, clear/reset sequences and randomized traffic vs a model.
module tb_data_ram;

  logic       clk;
  logic       rstn;
  logic [7:0] io_in;
  logic [7:0] io_out;

  data_ram_if #(.DATA_WIDTH(8), .BUS_WIDTH(8)) bus ();

  data_ram dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus    (bus),
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RAM_CLEAR_EN
  localparam int CLEAR_CYCLES = 256;
`else
  localparam int CLEAR_CYCLES = 0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_rd;
  bit         m_rd_known;
  logic [7:0] m_io;
  logic [7:0] m_h1, m_h2;
  int         m_busy_left;

  typedef struct {
    logic       rd;
    logic [7:0] ard;
    logic       wr;
    logic [7:0] awr;
    logic [7:0] dwr;
    logic [7:0] io;
    logic [7:0] exp_rd;
    logic [7:0] exp_io;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rd, input logic [7:0] ard, input logic wr,
                       input logic [7:0] awr, input logic [7:0] dwr);
    bus.ram_rd_en = rd;
    bus.addr_rd   = ard;
    bus.ram_wr_en = wr;
    bus.addr_wr   = awr;
    bus.data_wr   = dwr;
  endtask

  // One clock: update the model from the current inputs, step the DUT, compare.
  task automatic cycle();
    if (!rstn) begin
      m_rd        = 8'h00;
      m_rd_known  = 1'b1;
      m_io        = 8'h00;
      m_h1        = 8'h00;
      m_h2        = 8'h00;
      m_busy_left = CLEAR_CYCLES;
    end else begin
      if (m_busy_left > 0) begin
        m_mem[256 - m_busy_left]   = 8'h00;
        m_known[256 - m_busy_left] = 1'b1;
        m_busy_left--;
      end else begin
        if (bus.ram_rd_en) begin
          if (bus.ram_wr_en && bus.addr_wr == bus.addr_rd) begin
            m_rd = bus.data_wr; m_rd_known = 1'b1;
          end else if (bus.addr_rd == 8'hFF) begin
            m_rd = m_h2; m_rd_known = 1'b1;
          end else begin
            m_rd = m_mem[bus.addr_rd]; m_rd_known = m_known[bus.addr_rd];
          end
        end
        if (bus.ram_wr_en) begin
          m_mem[bus.addr_wr]   = bus.data_wr;
          m_known[bus.addr_wr] = 1'b1;
          if (bus.addr_wr == 8'hFF) m_io = bus.data_wr;
        end
      end
      m_h2 = m_h1;
      m_h1 = io_in;
    end
    @(posedge clk);
    #1;
    chk("busy", 32'(bus.ram_busy), 32'(m_busy_left > 0));
    chk("io_out", 32'(io_out), 32'(m_io));
    if (m_rd_known) chk("data_rd", 32'(bus.data_rd), 32'(m_rd));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.ram_busy === 1'b1 && n < 400) begin
      drive(0, 0, 0, 0, 0);
      cycle();
      n++;
    end
    chk("ready_timeout", 32'(bus.ram_busy), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 8'h10, 8'hA5, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 8'h10, 1'b0, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 8'h20, 8'h77, 8'h00, 8'hA5, 8'h00};
    vecs[4]  = '{1'b1, 8'h20, 1'b1, 8'h20, 8'h3C, 8'h00, 8'h3C, 8'h00};
    vecs[5]  = '{1'b1, 8'h20, 1'b0, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h02, 8'h22, 8'h00, 8'h3C, 8'h00};
    vecs[7]  = '{1'b1, 8'h02, 1'b1, 8'h01, 8'h11, 8'h00, 8'h22, 8'h00};
    vecs[8]  = '{1'b1, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'hFF, 8'h5A, 8'hC3, 8'h11, 8'h5A};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'hC3, 8'h11, 8'h5A};
    vecs[11] = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 8'hC3, 8'hC3, 8'h5A};
    vecs[12] = '{1'b1, 8'hFF, 1'b1, 8'hFF, 8'h99, 8'hC3, 8'h99, 8'h99};
    vecs[13] = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 8'hC3, 8'hC3, 8'h99};

    // Reset
    rstn  = 1'b0;
    io_in = 8'h00;
    drive(0, 0, 0, 0, 0);
    cycle();
    cycle();
    chk("rst_data_rd", 32'(bus.data_rd), 32'(0));
    chk("rst_io_out", 32'(io_out), 32'(0));
    chk("rst_busy", 32'(bus.ram_busy), 32'(CLEAR_CYCLES > 0));
    rstn = 1'b1;
    wait_ready();

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rd, vecs[i].ard, vecs[i].wr, vecs[i].awr, vecs[i].dwr);
      io_in = vecs[i].io;
      cycle();
      chk($sformatf("vec%0d_rd", i), 32'(bus.data_rd), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_io", i), 32'(io_out), 32'(vecs[i].exp_io));
    end
    drive(0, 0, 0, 0, 0);

`ifdef RAM_CLEAR_EN
    begin
      int n;
      logic [7:0] clr_addrs [3];
      clr_addrs[0] = 8'h00; clr_addrs[1] = 8'h7F; clr_addrs[2] = 8'hFE;

      // Full clear after a one-cycle reset
      rstn = 1'b0; cycle(); rstn = 1'b1;
      n = 0;
      while (bus.ram_busy === 1'b1 && n < 400) begin cycle(); n++; end
      chk("clear_len", 32'(n), 32'(256));
      foreach (clr_addrs[k]) begin
        drive(1, clr_addrs[k], 0, 0, 0); cycle();
        chk($sformatf("clear_rd_%h", clr_addrs[k]), 32'(bus.data_rd), 32'(0));
      end

      // Write 0x05, then reset again mid-clear with a write issued while busy
      drive(0, 0, 1, 8'h05, 8'h66); cycle();
      drive(0, 0, 0, 0, 0);
      rstn = 1'b0; cycle(); rstn = 1'b1;
      for (int c = 0; c < 100; c++) begin
        if (c == 50) drive(0, 0, 1, 8'h05, 8'hEE);
        else         drive(0, 0, 0, 0, 0);
        cycle();
      end
      drive(0, 0, 0, 0, 0);
      rstn = 1'b0; cycle(); rstn = 1'b1;
      n = 0;
      while (bus.ram_busy === 1'b1 && n < 400) begin cycle(); n++; end
      chk("restart_clear_len", 32'(n), 32'(256));
      drive(1, 8'h05, 0, 0, 0); cycle();
      chk("busy_write_ignored", 32'(bus.data_rd), 32'(0));
      drive(0, 0, 0, 0, 0);
    end
`endif

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      logic [7:0] ard, awr;
      ard = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      awr = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) awr = ard;
      drive(1'($urandom), ard, 1'($urandom), awr, 8'($urandom));
      io_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : io_in;
      rstn  = ($urandom_range(0, 499) != 0);
      cycle();
    end
    rstn = 1'b1;
    drive(0, 0, 0, 0, 0);
    wait_ready();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
